// File: rtl/obj_pkg.sv
// Shared types and constants for the object spawn-coordinate bank.
package obj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROLL  = 2'd1,
        ST_CHECK = 2'd2
    } obj_state_e;

    localparam int DEF_NUM_OBJ     = 10;
    localparam int DEF_X_W         = 8;
    localparam int DEF_NUM_SLOTS   = 16;
    localparam int DEF_SLOT_PITCH  = 10;
    localparam int DEF_X_OFFSET    = 2;
    localparam int DEF_INIT_STRIDE = 3;
    localparam int DEF_MAX_RETRY   = 3;

    // Galois mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] DEF_SEED  = 16'hACE1;

    // An odd stride against a power-of-two slot count spreads objects over distinct columns.
    function automatic int reset_col(input int i, input int stride, input int num_slots);
        return (i * stride) % num_slots;
    endfunction

endpackage

// File: rtl/obj_x_bank_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the column picker.
module lfsr16
    import obj_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_SEED
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [15:0] q
);

    // An all-zero seed would lock the register, so it falls back to the default.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEF_SEED : SEED;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= SEED_EFF;
        end else begin
            q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/obj_x_bank.sv
// Bank of registered spawn x coordinates; queued respawn requests are served
// lowest index first, with a bounded re-roll to avoid columns already in use.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for any pending request; latches lowest index
//   ROLL     | sample LFSR low bits as candidate column
//   CHECK    | clash test; re-roll or write x[idx] and pulse load_done
module obj_x_bank
    import obj_pkg::*;
#(
    parameter int          NUM_OBJ     = DEF_NUM_OBJ,
    parameter int          X_W         = DEF_X_W,
    parameter int          NUM_SLOTS   = DEF_NUM_SLOTS,
    parameter int          SLOT_PITCH  = DEF_SLOT_PITCH,
    parameter int          X_OFFSET    = DEF_X_OFFSET,
    parameter int          INIT_STRIDE = DEF_INIT_STRIDE,
    parameter int          MAX_RETRY   = DEF_MAX_RETRY,
    parameter logic [15:0] LFSR_SEED   = DEF_SEED
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_OBJ-1:0]     load_req,
    output logic [NUM_OBJ*X_W-1:0] x_flat,
    output logic [NUM_OBJ-1:0]     load_done,
    output logic                   busy
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int IDX_W  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_ROLL  = 2'(ST_ROLL);
    localparam logic [1:0] S_CHECK = 2'(ST_CHECK);

    if (longint'(SLOT_PITCH) * (NUM_SLOTS - 1) + X_OFFSET >= (longint'(1) << X_W)) begin : g_bad_geom
        $error("obj_x_bank: column grid does not fit in X_W bits");
    end
    if (NUM_SLOTS < 2 || (NUM_SLOTS & (NUM_SLOTS - 1)) != 0) begin : g_bad_slots
        $error("obj_x_bank: NUM_SLOTS must be a power of two >= 2");
    end
    if (INIT_STRIDE % 2 == 0) begin : g_bad_stride
        $error("obj_x_bank: INIT_STRIDE must be odd");
    end

    logic [1:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   first_idx;
    logic [SLOT_W-1:0]  cand;
    logic [RTY_W-1:0]   retry;
    logic [NUM_OBJ-1:0] pending;
    logic [NUM_OBJ-1:0] clr;
    logic [15:0]        lfsr_q;
    logic [SLOT_W-1:0]  col_all [NUM_OBJ];
    logic [X_W-1:0]     new_x;
    logic               clash;
    logic               write_en;
    logic               unused_lfsr_hi;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .q      (lfsr_q)
    );

    assign unused_lfsr_hi = ^lfsr_q[15:SLOT_W];

    always_comb begin
        first_idx = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (pending[i]) first_idx = IDX_W'(i);
        end
    end

    always_comb begin
        clash = 1'b0;
        for (int j = 0; j < NUM_OBJ; j++) begin
            if (IDX_W'(j) != idx && col_all[j] == cand) clash = 1'b1;
        end
    end

    // Retry count only climbs to MAX_RETRY, so inequality doubles as "retries left".
    assign write_en = (state == S_CHECK) && !(clash && retry != RTY_W'(MAX_RETRY));
    assign clr      = write_en ? (NUM_OBJ'(1) << idx) : '0;
    assign new_x    = X_W'(SLOT_PITCH) * X_W'(cand) + X_W'(X_OFFSET);
    assign busy     = (state != S_IDLE) || (|pending);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending   <= '0;
            load_done <= '0;
        end else begin
            pending   <= (pending & ~clr) | load_req;
            load_done <= clr;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            idx   <= '0;
            cand  <= '0;
            retry <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|pending) begin
                        idx   <= first_idx;
                        retry <= '0;
                        state <= S_ROLL;
                    end
                end
                S_ROLL: begin
                    cand  <= lfsr_q[SLOT_W-1:0];
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (write_en) begin
                        state <= S_IDLE;
                    end else begin
                        retry <= retry + 1'b1;
                        state <= S_ROLL;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Column is kept next to x so the clash compare never needs a divide.
    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
        localparam int RST_COL = reset_col(g, INIT_STRIDE, NUM_SLOTS);
        logic [X_W-1:0]    x_r;
        logic [SLOT_W-1:0] col_r;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                x_r   <= X_W'(SLOT_PITCH * RST_COL + X_OFFSET);
                col_r <= SLOT_W'(RST_COL);
            end else if (write_en && idx == IDX_W'(g)) begin
                x_r   <= new_x;
                col_r <= cand;
            end
        end

        assign x_flat[g*X_W +: X_W] = x_r;
        assign col_all[g]           = col_r;
    end

endmodule

// File: tb/tb_obj_x_bank.sv
// Self-checking bench for obj_x_bank: transaction-level model driven by a precomputed LFSR history.
module tb_obj_x_bank;

    localparam int NOBJ = 10;
    localparam int XW   = 8;
    localparam int HLEN = 8192;
    // Galois mask built from polynomial exponents 16,14,13,11 (bit e-1 for x^e)
    localparam logic [15:0] POLY_MASK = (16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10);

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic [NOBJ-1:0]      req0, req1, done0, done1;
    logic [NOBJ*XW-1:0]   x0, x1;
    logic                 busy0, busy1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [15:0] hist [HLEN];
    int pcol [2][NOBJ];
    int cx   [2][NOBJ];

    obj_x_bank dut0 (
        .clk(clk), .resetn(resetn), .load_req(req0),
        .x_flat(x0), .load_done(done0), .busy(busy0)
    );

    obj_x_bank #(.MAX_RETRY(0), .LFSR_SEED(16'h0000)) dut1 (
        .clk(clk), .resetn(resetn), .load_req(req1),
        .x_flat(x1), .load_done(done1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ POLY_MASK) : (v >> 1);
    endfunction

    function automatic int get_x(input int sel, input int i);
        return sel ? int'(x1[i*XW +: XW]) : int'(x0[i*XW +: XW]);
    endfunction

    function automatic void init_models();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < NOBJ; i++) begin
                pcol[s][i] = (i * 3) % 16;
                cx[s][i]   = 10 * pcol[s][i] + 2;
            end
    endfunction

    function automatic bit col_taken(input int sel, input int idx, input int c);
        for (int j = 0; j < NOBJ; j++)
            if (j != idx && pcol[sel][j] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Request latched at edge k: roll r samples the LFSR value after edge k+1+2r,
    // write lands at edge k+3+2r.
    task automatic predict(input int sel, input int k, input int idx, input int maxr,
                           output int w, output int c, output bit fr);
        int r;
        fr = 1'b0;
        c  = 0;
        for (r = 0; r <= maxr; r++) begin
            c  = int'(hist[k + 1 + 2*r] & 16'h000F);
            fr = !col_taken(sel, idx, c);
            if (fr || r == maxr) break;
        end
        w = k + 3 + 2*r;
        pcol[sel][idx] = c;
    endtask

    task automatic test_reset();
        int exp_x [NOBJ] = '{2, 32, 62, 92, 122, 152, 22, 52, 82, 112};
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < NOBJ; i++) begin
                if (get_x(s, i) !== exp_x[i]) begin
                    n_err++;
                    $display("FAIL reset_x dut%0d[%0d]: got %0d want %0d", s, i, get_x(s, i), exp_x[i]);
                end
                n_cmp++;
            end
        if (done0 !== '0 || done1 !== '0) begin
            n_err++;
            $display("FAIL reset_done: got %b/%b want 0", done0, done1);
        end
        n_cmp++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b/%b want 0", busy0, busy1);
        end
        n_cmp++;
    endtask

    task automatic test_single(input int idx);
        int k, w, c;
        bit fr;
        logic [NOBJ-1:0] exp_d;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        req0 = NOBJ'(1) << idx;
        k = cyc + 1;
        @(negedge clk);
        req0 = '0;
        predict(0, k, idx, 3, w, c, fr);
        if (busy0 !== 1'b1) begin
            n_err++;
            $display("FAIL single_busy: got %b want 1", busy0);
        end
        n_cmp++;
        for (int t = k + 1; t <= w + 1; t++) begin
            @(negedge clk);
            exp_d = (t == w) ? (NOBJ'(1) << idx) : '0;
            if (done0 !== exp_d) begin
                n_err++;
                $display("FAIL single_done obj%0d cyc%0d: got %b want %b", idx, t, done0, exp_d);
            end
            n_cmp++;
            if (t == w) begin
                cx[0][idx] = 10 * c + 2;
                for (int i = 0; i < NOBJ; i++) begin
                    if (get_x(0, i) !== cx[0][i]) begin
                        n_err++;
                        $display("FAIL single_x obj%0d x[%0d]: got %0d want %0d", idx, i, get_x(0, i), cx[0][i]);
                    end
                    n_cmp++;
                end
            end
        end
    endtask

    task automatic test_simultaneous(input logic [NOBJ-1:0] mask);
        int k, kk, n, last, wt, ct;
        int e_idx [NOBJ];
        int e_w   [NOBJ];
        int e_c   [NOBJ];
        bit fr, wr;
        logic [NOBJ-1:0] exp_d;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        req0 = mask;
        k = cyc + 1;
        @(negedge clk);
        req0 = '0;
        kk = k;
        n  = 0;
        for (int i = 0; i < NOBJ; i++) begin
            if (mask[i]) begin
                predict(0, kk, i, 3, wt, ct, fr);
                e_idx[n] = i;
                e_w[n]   = wt;
                e_c[n]   = ct;
                kk = wt;
                n++;
            end
        end
        last = kk;
        for (int t = k + 1; t <= last + 1; t++) begin
            @(negedge clk);
            exp_d = '0;
            wr = 1'b0;
            for (int e = 0; e < n; e++) begin
                if (e_w[e] == t) begin
                    exp_d[e_idx[e]] = 1'b1;
                    cx[0][e_idx[e]] = 10 * e_c[e] + 2;
                    wr = 1'b1;
                end
            end
            if (done0 !== exp_d) begin
                n_err++;
                $display("FAIL multi_done mask %b cyc%0d: got %b want %b", mask, t, done0, exp_d);
            end
            n_cmp++;
            if (wr) begin
                for (int i = 0; i < NOBJ; i++) begin
                    if (get_x(0, i) !== cx[0][i]) begin
                        n_err++;
                        $display("FAIL multi_x mask %b x[%0d]: got %0d want %0d", mask, i, get_x(0, i), cx[0][i]);
                    end
                    n_cmp++;
                end
            end
        end
    endtask

    // Waits for an LFSR phase whose first roll hits a held column, then requests.
    task automatic test_clash(input int sel);
        int idx, k, w, c, xo;
        bit fr, found, dup;
        logic [NOBJ-1:0] exp_d, d;
        idx = $urandom_range(0, NOBJ - 1);
        found = 1'b0;
        for (int tries = 0; tries < 200 && !found; tries++) begin
            @(negedge clk);
            if (col_taken(sel, idx, int'(hist[cyc + 2] & 16'h000F))) found = 1'b1;
        end
        if (!found) begin
            n_err++;
            $display("FAIL clash_setup dut%0d: got none want clashing phase", sel);
            n_cmp++;
            return;
        end
        if (sel == 1) req1 = NOBJ'(1) << idx;
        else          req0 = NOBJ'(1) << idx;
        k = cyc + 1;
        @(negedge clk);
        req0 = '0;
        req1 = '0;
        predict(sel, k, idx, (sel == 1) ? 0 : 3, w, c, fr);
        for (int t = k + 1; t <= w + 1; t++) begin
            @(negedge clk);
            d = (sel == 1) ? done1 : done0;
            exp_d = (t == w) ? (NOBJ'(1) << idx) : '0;
            if (d !== exp_d) begin
                n_err++;
                $display("FAIL clash_done dut%0d obj%0d cyc%0d: got %b want %b", sel, idx, t, d, exp_d);
            end
            n_cmp++;
            if (t == w) begin
                cx[sel][idx] = 10 * c + 2;
                xo = get_x(sel, idx);
                if (xo !== cx[sel][idx]) begin
                    n_err++;
                    $display("FAIL clash_x dut%0d obj%0d: got %0d want %0d", sel, idx, xo, cx[sel][idx]);
                end
                n_cmp++;
                dup = 1'b0;
                for (int j = 0; j < NOBJ; j++)
                    if (j != idx && get_x(sel, j) == xo) dup = 1'b1;
                if (dup !== !fr) begin
                    n_err++;
                    $display("FAIL clash_dup dut%0d obj%0d: got %b want %b", sel, idx, dup, !fr);
                end
                n_cmp++;
            end
        end
    endtask

    task automatic test_reassert();
        int k, w1, w2, c1, c2;
        bit fr;
        logic [NOBJ-1:0] exp_d;
        @(negedge clk);
        req0 = 10'b0000100000;
        k = cyc + 1;
        @(negedge clk);
        req0 = '0;
        predict(0, k, 5, 3, w1, c1, fr);
        predict(0, w1, 5, 3, w2, c2, fr);
        for (int t = k + 1; t <= w2 + 1; t++) begin
            @(negedge clk);
            exp_d = (t == w1 || t == w2) ? 10'b0000100000 : '0;
            if (done0 !== exp_d) begin
                n_err++;
                $display("FAIL reassert_done cyc%0d: got %b want %b", t, done0, exp_d);
            end
            n_cmp++;
            if (t == w1 || t == w2) begin
                cx[0][5] = 10 * ((t == w1) ? c1 : c2) + 2;
                if (get_x(0, 5) !== cx[0][5]) begin
                    n_err++;
                    $display("FAIL reassert_x cyc%0d: got %0d want %0d", t, get_x(0, 5), cx[0][5]);
                end
                n_cmp++;
            end
            req0 = (t == w1 - 1) ? 10'b0000100000 : '0;
        end
    endtask

    task automatic test_mid_reset();
        int exp_x [NOBJ] = '{2, 32, 62, 92, 122, 152, 22, 52, 82, 112};
        @(negedge clk);
        req0 = 10'b0000110000;
        @(negedge clk);
        req0 = '0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        for (int i = 0; i < NOBJ; i++) begin
            if (get_x(0, i) !== exp_x[i]) begin
                n_err++;
                $display("FAIL midreset_x[%0d]: got %0d want %0d", i, get_x(0, i), exp_x[i]);
            end
            n_cmp++;
        end
        if (done0 !== '0 || busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_ctl: got done %b busy %b want 0/0", done0, busy0);
        end
        n_cmp++;
        init_models();
        @(negedge clk);
        resetn = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done0 !== '0 || busy0 !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_quiet cyc%0d: got done %b busy %b want 0/0", t, done0, busy0);
            end
            n_cmp++;
        end
    endtask

    initial begin
        req0 = '0;
        req1 = '0;
        hist[0] = 16'hACE1;
        for (int n = 1; n < HLEN; n++) hist[n] = lfsr_next(hist[n-1]);
        init_models();
        repeat (3) @(negedge clk);
        test_reset();
        resetn = 1'b1;

        test_single(3);
        for (int i = 0; i < 6; i++) test_single($urandom_range(0, NOBJ - 1));

        test_simultaneous(10'b1000000101);
        for (int i = 0; i < 4; i++) test_simultaneous(NOBJ'($urandom_range(1, 1023)));

        test_clash(1);
        test_clash(0);
        test_clash(1);
        test_clash(0);

        test_reassert();
        test_mid_reset();
        test_single(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
